alu_zflag_deco: RTL and testbench

//  Datapath support block for the 8-bit single-cycle CPU. Holds three parts:
//   - a combinational ALU with a zero detect;
//   - the registered zero flag (Z), with a write enable;
//   - the 2-to-4 one-hot decoder that selects an output-port register.
//  The ALU result feeds the register-file write mux. Z feeds the control unit
//  for conditional jumps. The decoder takes instruction bits [1:0].

---
 rtl/alu_zflag_deco.sv | 82 ++++++++
 tb/tb_alu_zflag_deco.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_zflag_deco.sv
// Datapath support block for the 8-bit single-cycle CPU: combinational ALU with
// zero detect, the registered zero flag, and the 2-to-4 port-select decoder.
module alu_zflag_deco #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_alu,
  output logic [WIDTH-1:0] y,
  output logic             zalu,
  input  logic             wez,
  output logic             z,
  input  logic             sel0,
  input  logic             sel1,
  output logic             d0,
  output logic             d1,
  output logic             d2,
  output logic             d3
);

  logic [WIDTH-1:0] y_s;
  logic             zalu_s;
  logic             z_d;
  logic             z_q;
  logic [3:0]       dec_s;

  // ALU: all arithmetic wraps modulo 2^WIDTH; an unknown op falls to a defined zero result
  always_comb begin
    y_s = {WIDTH{1'b0}};
    case (op_alu)
      3'b000:  y_s = a;
      3'b001:  y_s = ~a;
      3'b010:  y_s = a + b;
      3'b011:  y_s = a - b;
      3'b100:  y_s = a & b;
      3'b101:  y_s = a | b;
      3'b110:  y_s = {WIDTH{1'b0}} - a;
      3'b111:  y_s = {WIDTH{1'b0}} - b;
      default: y_s = {WIDTH{1'b0}};
    endcase
    zalu_s = ~|y_s;
  end

  always_comb begin
    if (wez) begin
      z_d = zalu_s;
    end else begin
      z_d = z_q;
    end
  end

  // Zero flag; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (reset) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z_d;
    end
  end

  always_comb begin
    dec_s = 4'b0000;
    case ({sel1, sel0})
      2'b00:   dec_s = 4'b0001;
      2'b01:   dec_s = 4'b0010;
      2'b10:   dec_s = 4'b0100;
      2'b11:   dec_s = 4'b1000;
      default: dec_s = 4'b0001;
    endcase
  end

  assign y    = y_s;
  assign zalu = zalu_s;
  assign z    = z_q;
  assign d0   = dec_s[0];
  assign d1   = dec_s[1];
  assign d2   = dec_s[2];
  assign d3   = dec_s[3];

endmodule

// File: tb/tb_alu_zflag_deco.sv
// Self-checking bench for alu_zflag_deco: arithmetic reference model checked every
// negedge, plus directed vectors with hand-computed expectations.
module tb_alu_zflag_deco;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op_alu;
  logic [WIDTH-1:0] y;
  logic             zalu;
  logic             wez;
  logic             z;
  logic             sel0;
  logic             sel1;
  logic             d0, d1, d2, d3;

  int tests;
  int fails;
  logic check_en;
  logic model_z;

  alu_zflag_deco #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op_alu(op_alu), .y(y), .zalu(zalu),
    .wez(wez), .z(z), .sel0(sel0), .sel1(sel1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from plain integer arithmetic
  function automatic int model_y(input int op, input int ai, input int bi);
    case (op)
      0:       return ai;
      1:       return (MOD - 1) - ai;
      2:       return (ai + bi) % MOD;
      3:       return (ai - bi + MOD) % MOD;
      4:       return ai & bi;
      5:       return ai | bi;
      6:       return (MOD - ai) % MOD;
      7:       return (MOD - bi) % MOD;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Flag model: reset, else load zero-of-result when enabled, else hold
  always @(posedge clk) begin
    if (reset) model_z <= 1'b0;
    else if (wez) model_z <= (model_y(int'(op_alu), int'(a), int'(b)) == 0);
  end

  // Continuous compare against the model on the inactive edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_y", 32'(y), 32'(model_y(int'(op_alu), int'(a), int'(b))));
      chk("model_zalu", 32'(zalu), 32'(model_y(int'(op_alu), int'(a), int'(b)) == 0));
      chk("model_z", 32'(z), 32'(model_z));
      chk("model_dec", 32'({d3, d2, d1, d0}), 32'(1 << int'({sel1, sel0})));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string nm, input logic [2:0] op, input logic [7:0] av,
                     input logic [7:0] bv, input logic [7:0] ey, input logic ez);
    op_alu = op; a = av; b = bv;
    #1;
    chk({nm, "_y"}, 32'(y), 32'(ey));
    chk({nm, "_zalu"}, 32'(zalu), 32'(ez));
    tick();
  endtask

  logic [7:0] pats [0:5];

  initial begin
    tests = 0; fails = 0; check_en = 1'b0;
    reset = 1'b1; wez = 1'b1; a = 8'h00; b = 8'h00; op_alu = 3'b000;
    sel0 = 1'b0; sel1 = 1'b0;

    // Reset with wez high and zero result: flag must stay 0
    tick();
    chk("reset_z", 32'(z), 32'd0);
    check_en = 1'b1;
    reset = 1'b0;
    tick();
    chk("first_write_z", 32'(z), 32'd1);

    wez = 1'b0;
    vec("add_7f_01", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b0);
    vec("add_wrap",  3'b010, 8'hFF, 8'h01, 8'h00, 1'b1);
    vec("sub_eq",    3'b011, 8'h05, 8'h05, 8'h00, 1'b1);
    vec("sub_neg",   3'b011, 8'h03, 8'h05, 8'hFE, 1'b0);
    vec("not_a",     3'b001, 8'hF0, 8'h3C, 8'h0F, 1'b0);
    vec("and",       3'b100, 8'hF0, 8'h3C, 8'h30, 1'b0);
    vec("or",        3'b101, 8'hF0, 8'h3C, 8'hFC, 1'b0);
    vec("neg_a",     3'b110, 8'hF0, 8'h3C, 8'h10, 1'b0);
    vec("neg_b",     3'b111, 8'hF0, 8'h3C, 8'hC4, 1'b0);
    vec("pass_a",    3'b000, 8'hA5, 8'h3C, 8'hA5, 1'b0);
    vec("neg_zero",  3'b110, 8'h00, 8'h01, 8'h00, 1'b1);

    // Flag hold: set z, then it must ignore a nonzero result while wez is low
    op_alu = 3'b000; a = 8'h00; wez = 1'b1;
    tick();
    chk("z_set", 32'(z), 32'd1);
    wez = 1'b0; a = 8'h42;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("z_hold", 32'(z), 32'd1);
    end
    wez = 1'b1;
    tick();
    chk("z_clear", 32'(z), 32'd0);

    // Reset beats a simultaneous write of a zero result
    a = 8'h00; tick();
    chk("z_set2", 32'(z), 32'd1);
    a = 8'h00; reset = 1'b1; tick();
    chk("reset_prio", 32'(z), 32'd0);
    reset = 1'b0;

    // Decoder sweep
    for (int i = 0; i < 4; i++) begin
      {sel1, sel0} = 2'(i);
      #1;
      chk("decoder", 32'({d3, d2, d1, d0}), 32'(1 << i));
      tick();
    end

    // Broad sweep checked by the model, toggling wez
    pats[0] = 8'h00; pats[1] = 8'h01; pats[2] = 8'h7F;
    pats[3] = 8'h80; pats[4] = 8'hFF; pats[5] = 8'h5A;
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < 6; i++) begin
        op_alu = 3'(op); a = pats[i]; b = pats[(i + op) % 6];
        wez = 1'((i + op) % 2);
        {sel1, sel0} = 2'(i + op);
        tick();
      end
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
